// File: rtl/beta_mem_ctrl_pkg.sv
// Shared MAP-decoder definitions for the beta state-metric SRAM sequencer.
// Holds the default frame geometry and the sequencer state encoding.
package beta_mem_ctrl_pkg;

    localparam int N_STATES   = 8;   // trellis states per step (metrics per SRAM row)
    localparam int N_STEPS    = 9;   // trellis steps per frame
    localparam int ADDR_WIDTH = 8;   // SRAM addr_b width
    localparam int STEP_WIDTH = 4;   // width of step indices

    // Sequencer states; explicit codes keep the encoding stable for legacy tools.
    typedef enum logic [2:0] {
        BC_IDLE         = 3'd0,
        BC_WRITE        = 3'd1,
        BC_READ_ISSUE   = 3'd2,
        BC_READ_PRESENT = 3'd3,
        BC_DONE         = 3'd4
    } beta_ctrl_state_t;

endpackage : beta_mem_ctrl_pkg

// File: rtl/beta_mem_ctrl.sv
// Beta state-metric SRAM sequencer.
// Writes one frame of backward-recursion vectors from step N_STEPS-2 down
// to 0 (step N_STEPS-1 keeps its preloaded termination metrics), then reads
// steps 0..N_STEPS-1 back to the LLR unit under a valid/ready handshake.
// Beta data flows directly into the SRAM; only control, address and
// handshakes are produced here.
module beta_mem_ctrl #(
    parameter int N_STATES   = beta_mem_ctrl_pkg::N_STATES,
    parameter int N_STEPS    = beta_mem_ctrl_pkg::N_STEPS,
    parameter int ADDR_WIDTH = beta_mem_ctrl_pkg::ADDR_WIDTH,
    parameter int STEP_WIDTH = beta_mem_ctrl_pkg::STEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [STEP_WIDTH-1:0] wr_step,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [STEP_WIDTH-1:0] rd_step,
    output logic                  busy,
    output logic                  done
);

    import beta_mem_ctrl_pkg::*;

    // N_STATES is a power of two, so the row address is a plain shift.
    localparam int                    ADDR_SHIFT  = $clog2(N_STATES);
    localparam logic [STEP_WIDTH-1:0] STEP_ZERO   = {STEP_WIDTH{1'b0}};
    localparam logic [STEP_WIDTH-1:0] STEP_ONE    = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_WIDTH-1:0] FIRST_WSTEP = STEP_WIDTH'(N_STEPS - 2);
    localparam logic [STEP_WIDTH-1:0] LAST_RSTEP  = STEP_WIDTH'(N_STEPS - 1);

    beta_ctrl_state_t      state_q, state_d;
    logic [STEP_WIDTH-1:0] wstep_q, wstep_d;
    logic [STEP_WIDTH-1:0] rstep_q, rstep_d;
    logic                  rd_valid_q;
    logic                  done_q;

    logic                  wr_ready_s;
    logic                  sram_we_s;
    logic [STEP_WIDTH-1:0] addr_step_s;

    // Next-state and step-counter update for the write/read sequence.
    always_comb begin
        state_d = state_q;
        wstep_d = wstep_q;
        rstep_d = rstep_q;
        case (state_q)
            BC_IDLE: begin
                if (start) begin
                    state_d = BC_WRITE;
                    wstep_d = FIRST_WSTEP;
                end else begin
                    state_d = BC_IDLE;
                end
            end
            BC_WRITE: begin
                if (wr_valid) begin
                    if (wstep_q == STEP_ZERO) begin
                        state_d = BC_READ_ISSUE;
                        rstep_d = STEP_ZERO;
                    end else begin
                        wstep_d = wstep_q - STEP_ONE;
                    end
                end else begin
                    state_d = BC_WRITE;
                end
            end
            BC_READ_ISSUE: begin
                state_d = BC_READ_PRESENT;
            end
            BC_READ_PRESENT: begin
                if (rd_ready) begin
                    if (rstep_q == LAST_RSTEP) begin
                        state_d = BC_DONE;
                    end else begin
                        rstep_d = rstep_q + STEP_ONE;
                        state_d = BC_READ_ISSUE;
                    end
                end else begin
                    state_d = BC_READ_PRESENT;
                end
            end
            BC_DONE: begin
                state_d = BC_IDLE;
            end
            default: begin
                state_d = BC_IDLE;
            end
        endcase
    end

    // State, counters and registered handshake outputs; reset abandons any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BC_IDLE;
            wstep_q    <= STEP_ZERO;
            rstep_q    <= STEP_ZERO;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wstep_q    <= wstep_d;
            rstep_q    <= rstep_d;
            rd_valid_q <= (state_d == BC_READ_PRESENT);
            done_q     <= (state_d == BC_DONE);
        end
    end

    // SRAM control decode; the write strobe follows wr_valid with no added delay.
    always_comb begin
        wr_ready_s  = 1'b0;
        sram_we_s   = 1'b0;
        addr_step_s = STEP_ZERO;
        case (state_q)
            BC_IDLE: begin
                addr_step_s = STEP_ZERO;
            end
            BC_WRITE: begin
                wr_ready_s  = 1'b1;
                sram_we_s   = wr_valid;
                addr_step_s = wstep_q;
            end
            BC_READ_ISSUE: begin
                addr_step_s = rstep_q;
            end
            BC_READ_PRESENT: begin
                // Holding the address keeps the SRAM re-reading the same row,
                // so the presented data stays stable during backpressure.
                addr_step_s = rstep_q;
            end
            BC_DONE: begin
                addr_step_s = STEP_ZERO;
            end
            default: begin
                addr_step_s = STEP_ZERO;
            end
        endcase
    end

    assign wr_ready  = wr_ready_s;
    assign sram_we   = sram_we_s;
    assign sram_addr = ADDR_WIDTH'(addr_step_s) << ADDR_SHIFT;
    assign wr_step   = wstep_q;
    assign rd_step   = rstep_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != BC_IDLE);

endmodule : beta_mem_ctrl

// File: tb/tb_beta_mem_ctrl.sv
// Self-checking bench for beta_mem_ctrl with a behavioural SRAM and an
// expected-content table for the beta rows.
module tb_beta_mem_ctrl;

    localparam int NS = 8;   // states per step
    localparam int NT = 9;   // steps per frame
    localparam int AW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          wr_valid;
    logic          wr_ready;
    logic [SW-1:0] wr_step;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic          rd_valid;
    logic          rd_ready;
    logic [SW-1:0] rd_step;
    logic          busy;
    logic          done;

    logic [7:0] wr_data   [NS];
    logic [7:0] out_data  [NS];
    logic [7:0] load_data [NS];
    logic       load_en;
    logic [7:0] sram      [NS*NT];
    logic [7:0] ref_mem   [NT][NS];
    logic       top_row_hit = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    beta_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_step   (wr_step),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_step   (rd_step),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural SRAM: synchronous write, registered read of a whole row.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < NS; i++) sram[(NT-1)*NS + i] <= load_data[i];
        end else if (sram_we) begin
            for (int i = 0; i < NS; i++)
                if (int'(sram_addr) + i < NS*NT) sram[int'(sram_addr) + i] <= wr_data[i];
            if (int'(sram_addr) >= (NT-1)*NS) top_row_hit <= 1'b1;
        end else begin
            for (int i = 0; i < NS; i++)
                if (int'(sram_addr) + i < NS*NT) out_data[i] <= sram[int'(sram_addr) + i];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
        chk({tag, "_wr_step"},   32'(wr_step),   32'd0);
        chk({tag, "_sram_we"},   32'(sram_we),   32'd0);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        chk({tag, "_rd_step"},   32'(rd_step),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // One frame: gapless = no wait states, stalls = the directed write/read
    // stalls, abort_rstep = step at which reset hits READ_PRESENT (-1: none).
    task automatic run_frame(input bit gapless, input bit stalls, input int abort_rstep);
        int         written;
        int         wcyc;
        int         rcyc;
        int         stall_cnt;
        int         s;
        int         guard;
        bit         v;
        bit         r;
        logic [7:0] vec [NS];

        start = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        #2;
        chk("idle_busy",     32'(busy),     32'd0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);
        cyc();
        start = 1'b0;

        // Write phase: expected step is the next one not yet accepted.
        written = 0; wcyc = 0; stall_cnt = 0;
        while (written < NT-1 && wcyc < 200) begin
            s = NT - 2 - written;
            if (stalls && s == 4 && stall_cnt < 3) begin
                v = 1'b0; stall_cnt++;
            end else if (gapless) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            start = (wcyc == 3);   // must be ignored outside IDLE
            for (int i = 0; i < NS; i++) begin
                vec[i]     = 8'($urandom);
                wr_data[i] = vec[i];
            end
            wr_valid = v;
            #2;
            chk("wr_ready",  32'(wr_ready),  32'd1);
            chk("wr_step",   32'(wr_step),   32'(s));
            chk("wr_addr",   32'(sram_addr), 32'(s * NS));
            chk("wr_we",     32'(sram_we),   32'(v));
            chk("wr_busy",   32'(busy),      32'd1);
            chk("wr_rvalid", 32'(rd_valid),  32'd0);
            if (v) begin
                for (int i = 0; i < NS; i++) ref_mem[s][i] = vec[i];
                written++;
            end
            wcyc++;
            cyc();
        end
        wr_valid = 1'b0; start = 1'b0;
        chk("write_count", 32'(written), 32'(NT-1));
        if (gapless) chk("write_cycles", 32'(wcyc), 32'(NT-1));

        // Read phase: one issue cycle, then present until handshake.
        rcyc = 0;
        for (int st = 0; st < NT; st++) begin
            rd_ready = 1'b0;
            #2;
            chk("iss_rvalid", 32'(rd_valid),  32'd0);
            chk("iss_we",     32'(sram_we),   32'd0);
            chk("iss_addr",   32'(sram_addr), 32'(st * NS));
            chk("iss_done",   32'(done),      32'd0);
            cyc(); rcyc++;
            stall_cnt = 0; guard = 0; r = 1'b0;
            while (!r && guard < 50) begin
                if (stalls && st == 2 && stall_cnt < 5) begin
                    r = 1'b0; stall_cnt++;
                end else if (gapless) begin
                    r = 1'b1;
                end else begin
                    r = ($urandom_range(0, 2) != 0);
                end
                rd_ready = r;
                #2;
                chk("pr_rvalid", 32'(rd_valid),  32'd1);
                chk("pr_step",   32'(rd_step),   32'(st));
                chk("pr_addr",   32'(sram_addr), 32'(st * NS));
                chk("pr_we",     32'(sram_we),   32'd0);
                for (int i = 0; i < NS; i++)
                    chk("pr_data", 32'(out_data[i]), 32'(ref_mem[st][i]));
                if (st == abort_rstep) begin
                    #1 rst = 1'b1;
                    #1;
                    chk_all_zero("async_rst");
                    rd_ready = 1'b0;
                    cyc();
                    rst = 1'b0;
                    return;
                end
                guard++; rcyc++;
                cyc();
            end
        end
        rd_ready = 1'b0;
        #2;
        chk("done_pulse", 32'(done),     32'd1);
        chk("done_busy",  32'(busy),     32'd1);
        chk("done_rv",    32'(rd_valid), 32'd0);
        if (gapless) chk("read_cycles", 32'(rcyc), 32'(2*NT));
        cyc();
        #2;
        chk("post_done",  32'(done),      32'd0);
        chk("post_busy",  32'(busy),      32'd0);
        chk("post_wrdy",  32'(wr_ready),  32'd0);
        chk("post_addr",  32'(sram_addr), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; load_en = 1'b1;
        for (int i = 0; i < NS; i++) begin
            wr_data[i]          = 8'd0;
            load_data[i]        = 8'($urandom);
            ref_mem[NT-1][i]    = load_data[i];
        end
        #3;
        chk_all_zero("por");
        cyc();
        cyc();
        load_en = 1'b0;
        rst = 1'b0;
        cyc();

        run_frame(1'b0, 1'b1, -1);  // random traffic with directed stalls
        run_frame(1'b0, 1'b0, 5);   // reset in READ_PRESENT at step 5
        run_frame(1'b1, 1'b0, -1);  // gapless frame, cycle counts
        run_frame(1'b0, 1'b0, -1);  // random traffic
        run_frame(1'b0, 1'b1, -1);

        chk("top_row_never_written", 32'(top_row_hit), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_beta_mem_ctrl
